// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared N-bit ALU: accept one op,
// register operands, evaluate, then hold the registered result until consumed.

module ALU_N_bits #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   ctrl,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z
);
    logic [N-1:0] bx;
    logic [N:0]   sum;

    always_comb begin
        // ctrl[0] selects a + ~b + 1 when ctrl[1] picks the adder path
        bx     = ctrl[0] ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, ctrl[0]};
        result = sum[N-1:0];
        c      = sum[N];
        v      = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);
        if (ctrl[1]) begin
            result = ctrl[0] ? (a | b) : (a & b);
            c      = 1'b0;
            v      = 1'b0;
        end
        n = result[N-1];
        z = ~|result;
    end
endmodule

module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_result,
    output logic         resp_v,
    output logic         resp_c,
    output logic         resp_n,
    output logic         resp_z
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state, state_nxt;
    logic         last;
    logic [N-1:0] a_q, b_q;
    logic [1:0]   op_q;
    logic         id_q;
    logic         gnt_id;
    logic         accept;
    logic [N-1:0] alu_result;
    logic         alu_v, alu_c, alu_n, alu_z;

    ALU_N_bits #(.N(N)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .ctrl   (op_q),
        .result (alu_result),
        .v      (alu_v),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        // on a tie the requester that did not win last time goes first
        if (req0_valid && req1_valid) gnt_id = ~last;
        else if (req1_valid)          gnt_id = 1'b1;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !gnt_id;
                req1_ready = req1_valid &&  gnt_id;
                accept     = req0_ready || req1_ready;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last        <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_v      <= 1'b0;
            resp_c      <= 1'b0;
            resp_n      <= 1'b0;
            resp_z      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q  <= gnt_id ? req1_a  : req0_a;
                    b_q  <= gnt_id ? req1_b  : req0_b;
                    op_q <= gnt_id ? req1_op : req0_op;
                    id_q <= gnt_id;
                    last <= gnt_id;
                end
                EXEC: begin
                    resp_valid  <= 1'b1;
                    resp_id     <= id_q;
                    resp_result <= alu_result;
                    resp_v      <= alu_v;
                    resp_c      <= alu_c;
                    resp_n      <= alu_n;
                    resp_z      <= alu_z;
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter: arithmetic reference model,
// grant/latency model and a response scoreboard checked by a negedge monitor.

module tb_alu_arbiter;
    localparam int N = 4;

    typedef struct {
        logic         id;
        logic [N-1:0] result;
        logic         v, c, n, z;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic         resp_valid, resp_ready = 1'b1, resp_id;
    logic [N-1:0] resp_result;
    logic         resp_v, resp_c, resp_n, resp_z;

    int checks = 0;
    int errors = 0;

    resp_t exp_q[$];
    bit    busy = 0;
    int    age = 0;
    bit    last_id = 1;
    bit    acc0 = 0, acc1 = 0;
    bit    hold_pending = 0;
    resp_t held;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result),
        .resp_v(resp_v), .resp_c(resp_c), .resp_n(resp_n), .resp_z(resp_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input logic [N-1:0] x);
        return x[N-1] ? int'(x) - (1 << N) : int'(x);
    endfunction

    // Reference ALU from plain integer arithmetic
    function automatic resp_t model(input bit id, input logic [N-1:0] a,
                                    input logic [N-1:0] b, input logic [1:0] op);
        resp_t r;
        int u, s;
        r.id = id; r.v = 0; r.c = 0;
        case (op)
            2'd0: begin
                u = int'(a) + int'(b);
                r.result = N'(u % (1 << N));
                r.c = (u >= (1 << N));
                s = to_signed(a) + to_signed(b);
                r.v = (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
            end
            2'd1: begin
                u = int'(a) - int'(b) + (1 << N);
                r.result = N'(u % (1 << N));
                r.c = (a >= b);
                s = to_signed(a) - to_signed(b);
                r.v = (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
            end
            2'd2: r.result = a & b;
            default: r.result = a | b;
        endcase
        r.n = r.result[N-1];
        r.z = (r.result == 0);
        return r;
    endfunction

    // Monitor: grant rule, latency, hold stability, scoreboard
    always @(negedge clk) begin
        bit    gid, e0, e1;
        resp_t e;
        acc0 = 0; acc1 = 0;
        if (rst) begin
            exp_q.delete();
            busy = 0; age = 0; last_id = 1; hold_pending = 0;
        end else begin
            if (busy) age++;
            gid = (req0_valid && req1_valid) ? !last_id : req1_valid;
            e0 = !busy && req0_valid && !gid;
            e1 = !busy && req1_valid && gid;
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("resp_valid", resp_valid, busy && age >= 2);
            if (hold_pending) begin
                chk("hold_id", resp_id, held.id);
                chk("hold_result", resp_result, held.result);
                chk("hold_flags", {resp_v, resp_c, resp_n, resp_z},
                    {held.v, held.c, held.n, held.z});
            end
            hold_pending = 0;
            if (resp_valid && !resp_ready) begin
                hold_pending = 1;
                held.id = resp_id; held.result = resp_result;
                held.v = resp_v; held.c = resp_c; held.n = resp_n; held.z = resp_z;
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_result", resp_result, e.result);
                    chk("resp_flags", {resp_v, resp_c, resp_n, resp_z}, {e.v, e.c, e.n, e.z});
                end
                busy = 0; age = 0;
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back(model(0, req0_a, req0_b, req0_op));
                last_id = 0; busy = 1; age = 0; acc0 = 1;
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back(model(1, req1_a, req1_b, req1_op));
                last_id = 1; busy = 1; age = 0; acc1 = 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit vld, input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        req0_valid = vld; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input bit vld, input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        req1_valid = vld; req1_a = a; req1_b = b; req1_op = op;
    endtask

    initial begin
        cyc(2);
        rst = 0;
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_flags", {resp_v, resp_c, resp_n, resp_z}, 0);
        cyc(1);

        // req0 add 0111 + 0001
        set0(1, 4'b0111, 4'b0001, 2'd0);
        cyc(1); set0(0, 0, 0, 0);
        cyc(1);
        @(negedge clk);
        chk("t1_valid", resp_valid, 1);
        chk("t1_result", resp_result, 4'b1000);
        chk("t1_flags", {resp_v, resp_c, resp_n, resp_z}, 4'b1010);
        cyc(2);

        // req1 sub 0011 - 0011
        set1(1, 4'b0011, 4'b0011, 2'd1);
        cyc(1); set1(0, 0, 0, 0);
        cyc(1);
        @(negedge clk);
        chk("t2_result", resp_result, 4'b0000);
        chk("t2_flags", {resp_v, resp_c, resp_n, resp_z}, 4'b0101);
        cyc(2);

        // both continuously valid: alternating grants
        set0(1, 4'b1100, 4'b1010, 2'd2);
        set1(1, 4'b1100, 4'b0011, 2'd3);
        cyc(14);
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        cyc(4);

        // backpressure for 5 cycles
        resp_ready = 0;
        set0(1, 4'b1001, 4'b0110, 2'd1);
        cyc(1); set0(0, 0, 0, 0);
        cyc(7);
        resp_ready = 1;
        cyc(3);

        // reset during EXEC
        set0(1, 4'b0101, 4'b0011, 2'd0);
        cyc(1); set0(0, 0, 0, 0);
        rst = 1; cyc(1); rst = 0;
        cyc(4);
        set0(1, 4'b0001, 4'b0001, 2'd0); set1(1, 4'b0010, 4'b0001, 2'd1);
        cyc(1); set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        cyc(4);

        // reset during RESP with consumer stalled
        resp_ready = 0;
        set1(1, 4'b1111, 4'b0001, 2'd0);
        cyc(1); set1(0, 0, 0, 0);
        cyc(2);
        rst = 1; cyc(1); rst = 0; resp_ready = 1;
        cyc(4);

        // req0 pulse while req1 is served
        set1(1, 4'b0110, 4'b0011, 2'd3);
        cyc(1); set1(0, 0, 0, 0);
        set0(1, 4'b0001, 4'b0010, 2'd0);
        cyc(1); set0(0, 0, 0, 0);
        cyc(5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || acc0)
                set0($urandom_range(0, 1), N'($urandom), N'($urandom), 2'($urandom));
            else if ($urandom_range(0, 15) == 0)
                req0_valid = 0;
            if (!req1_valid || acc1)
                set1($urandom_range(0, 1), N'($urandom), N'($urandom), 2'($urandom));
            else if ($urandom_range(0, 15) == 0)
                req1_valid = 0;
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 249) == 0);
            cyc(1);
        end
        rst = 0;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        resp_ready = 1;
        cyc(8);
        chk("drain_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences and shares one ALU_N_bits instance (add/sub/and/or, flags v c n z) between two requesters.
- Each requester presents operands and an op over a valid/ready handshake.
- The block arbitrates round-robin, registers the operands, runs the ALU, registers the result and flags, and returns them on a shared response channel with backpressure.
- It sits between the lab's control logic and the ALU, so no requester drives the ALU directly.

Parameters:
- N, 4, operand/result width in bits; passed unchanged to ALU_N_bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  N  requester 0 operand a.
- req0_b  in  N  requester 0 operand b.
- req0_op  in  2  requester 0 ALU control: 00 add, 01 sub (a-b), 10 and, 11 or.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- resp_valid  out  1  response result and flags valid.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_id  out  1  requester that issued the answered operation.
- resp_result  out  N  ALU result.
- resp_v, resp_c, resp_n, resp_z  out  1 each  ALU flags for that operation.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, applied only at clk edge.
- Reset values:
  - state=IDLE, resp_valid=0, resp_id=0, resp_result=0, all resp flags=0.
  - Operand/op registers are 0.
  - RR pointer last=1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: accepting requests.
  - EXEC: operands registered; ALU evaluates them.
  - RESP: result held for the consumer.
- IDLE, grant logic (combinational):
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the requester != last.
  - reqX_ready = (state==IDLE) & granted X. At most one ready is high per cycle; neither is high outside IDLE.
- Handshake accept at edge with valid&ready:
  - Capture a, b, op and id into registers.
  - last <= id.
  - State -> EXEC.
  - With no valid requests, stay in IDLE.
- EXEC:
  - ALU is driven from the registered a/b/op only. Requester inputs are don't-care after accept.
  - At the next edge: resp_result/flags <= ALU outputs, resp_id <= id, resp_valid <= 1, state -> RESP.
- RESP:
  - resp_* are held stable while resp_valid=1 & resp_ready=0, for any number of cycles.
  - On an edge with resp_ready=1: resp_valid <= 0, state -> IDLE. resp_result/flags keep their last values.
  - No new request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Accept at edge t gives resp_valid=1 after edge t+1, i.e. visible in cycle t+1 for sampling at edge t+2.
  - Minimum 3 cycles per operation.
- Requester rules:
  - A requester holds valid, a, b and op stable until it sees ready.
  - Dropping valid before ready is legal; that request is simply never granted.
- Arithmetic (as ALU_N_bits defines it):
  - Sub computes a + ~b + 1. c=1 means no borrow.
  - v is signed overflow for add/sub.
  - c and v are forced to 0 for and/or.
  - n = result[N-1]; z = (result==0).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Reset mid-operation:
  - rst in EXEC or RESP discards the operation.
  - Next cycle: resp_valid=0, state=IDLE, last=1.
  - No response is ever emitted for the discarded operation.
  - rst dominates any simultaneous handshake.

Test Plan:
- Reset, then req0 add a=0111 b=0001 -> req0_ready=1 in cycle 0; resp_valid=1 two edges later with resp_id=0, result=1000, v=1, n=1, c=0, z=0.
- req1 sub a=0011 b=0011 with resp_ready tied 1 -> result=0000, z=1, c=1, v=0, n=0, resp_id=1; resp_valid high exactly one cycle; back in IDLE next cycle.
- Both valid continuously after reset (req0 and 1100&1010, req1 or 1100|0011) -> grant order 0,1,0,1; responses alternate result=1000 (n=1, c=v=0) and 1111 (n=1).
- resp_ready held 0 for 5 cycles with a pending response -> resp_* stable all 5 cycles; req0_ready=req1_ready=0 throughout; completes on the first resp_ready=1 edge.
- rst asserted during EXEC, then during RESP (separate runs) -> resp_valid=0 the following cycle, no response appears afterwards, next tie grants requester 0.
- req0_valid pulsed high one cycle while req1 is being served, then dropped -> no grant to 0, no spurious response.
